// File: rtl/hazard_md_ctrl.sv
// Hazard control for a 5-stage MIPS pipeline: stalls, forwarding selects and mult/div busy tracking.
// Define HAZARD_MD_STALL_EN to build the mult/div busy counter; otherwise md_busy/stall_md tie to 0.
module hazard_md_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic       Tuse_rs0,
    input  logic       Tuse_rs1,
    input  logic       Tuse_rt0,
    input  logic       Tuse_rt1,
    input  logic       Tuse_rt2,
    input  logic [4:0] A1_E,
    input  logic [4:0] A2_E,
    input  logic [4:0] A3_E,
    input  logic [4:0] A2_M,
    input  logic [4:0] A3_M,
    input  logic [4:0] A3_W,
    input  logic [2:0] res_E,
    input  logic [2:0] res_M,
    input  logic [2:0] res_W,
    input  logic       md_start_E,
    input  logic       md_div_E,
    input  logic       md_use_D,
    output logic       stall,
    output logic       clrE,
    output logic       stall_md,
    output logic [1:0] fwd_rs_D,
    output logic [1:0] fwd_rt_D,
    output logic [1:0] fwd_rs_E,
    output logic [1:0] fwd_rt_E,
    output logic [1:0] fwd_rt_M,
    output logic       md_busy
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned RES_W = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [RES_W-1:0] RES_ALU = RES_W'(1);
    localparam logic [RES_W-1:0] RES_DM  = RES_W'(2);
    localparam logic [RES_W-1:0] RES_PC  = RES_W'(3);
    localparam logic [RES_W-1:0] RES_MD  = RES_W'(4);

    localparam logic [SEL_W-1:0] FWD_NONE = SEL_W'(0);
    localparam logic [SEL_W-1:0] FWD_E    = SEL_W'(1);
    localparam logic [SEL_W-1:0] FWD_M    = SEL_W'(2);
    localparam logic [SEL_W-1:0] FWD_W    = SEL_W'(3);

    // A stage writes a register only with a nonzero target and a real result class.
    function automatic logic writes(input logic [REG_W-1:0] a3, input logic [RES_W-1:0] res);
        return (a3 != '0) && (res == RES_ALU || res == RES_DM || res == RES_PC || res == RES_MD);
    endfunction

    function automatic logic [1:0] tnew_e(input logic [RES_W-1:0] res);
        case (res)
            RES_ALU: return 2'd1;
            RES_DM:  return 2'd2;
            RES_MD:  return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_m(input logic [RES_W-1:0] res);
        return (res == RES_DM) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic hazard(input logic [REG_W-1:0] a, input logic rd,
                                    input logic [1:0] tuse, input logic wr,
                                    input logic [REG_W-1:0] a3, input logic [1:0] tnew);
        return rd && wr && (a == a3) && (tnew > tuse);
    endfunction

    function automatic logic [SEL_W-1:0] fwd_sel(input logic e_hit, input logic m_hit,
                                                 input logic w_hit);
        if (e_hit)      return FWD_E;
        else if (m_hit) return FWD_M;
        else if (w_hit) return FWD_W;
        else            return FWD_NONE;
    endfunction

    logic       rs_read_c, rt_read_c;
    logic [1:0] rs_tuse_c, rt_tuse_c;
    logic       wr_e_c, wr_m_c, wr_w_c;
    logic       e_ok_c, m_ok_c;
    logic       data_stall_c;
    logic       md_busy_c;
    logic       stall_md_c;

    assign rs_read_c = Tuse_rs0 | Tuse_rs1;
    assign rs_tuse_c = Tuse_rs0 ? 2'd0 : 2'd1;
    assign rt_read_c = Tuse_rt0 | Tuse_rt1 | Tuse_rt2;
    assign rt_tuse_c = Tuse_rt0 ? 2'd0 : (Tuse_rt1 ? 2'd1 : 2'd2);

    assign wr_e_c = writes(A3_E, res_E);
    assign wr_m_c = writes(A3_M, res_M);
    assign wr_w_c = writes(A3_W, res_W);

    // Forwardable only when the producing stage already holds the final value.
    assign e_ok_c = wr_e_c && (tnew_e(res_E) == 2'd0);
    assign m_ok_c = wr_m_c && (tnew_m(res_M) == 2'd0);

    assign data_stall_c =
        hazard(A1_D, rs_read_c, rs_tuse_c, wr_e_c, A3_E, tnew_e(res_E)) |
        hazard(A1_D, rs_read_c, rs_tuse_c, wr_m_c, A3_M, tnew_m(res_M)) |
        hazard(A2_D, rt_read_c, rt_tuse_c, wr_e_c, A3_E, tnew_e(res_E)) |
        hazard(A2_D, rt_read_c, rt_tuse_c, wr_m_c, A3_M, tnew_m(res_M));

`ifdef HAZARD_MD_STALL_EN
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(5);
    localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(10);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

    md_state_t        md_state;
    logic [CNT_W-1:0] md_cnt;

    // Busy counter: a start in BUSY is ignored, IDLE is re-entered as the count hits zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_state <= MD_IDLE;
            md_cnt   <= '0;
        end else begin
            case (md_state)
                MD_IDLE: begin
                    if (md_start_E) begin
                        md_cnt   <= md_div_E ? DIV_CYC : MUL_CYC;
                        md_state <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - CNT_W'(1);
                    if (md_cnt == CNT_W'(1)) md_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign md_busy_c  = (md_state == MD_BUSY) | md_start_E;
    assign stall_md_c = md_use_D & md_busy_c;
`else
    logic md_unused;
    assign md_unused  = ^{clk, md_start_E, md_div_E, md_use_D};
    assign md_busy_c  = 1'b0;
    assign stall_md_c = 1'b0;
`endif

    // All outputs are forced low while reset is held.
    assign md_busy  = reset & md_busy_c;
    assign stall_md = reset & stall_md_c;
    assign stall    = reset & (data_stall_c | stall_md_c);
    assign clrE     = stall;

    assign fwd_rs_D = reset ? fwd_sel(e_ok_c && A1_D == A3_E, m_ok_c && A1_D == A3_M,
                                      wr_w_c && A1_D == A3_W) : FWD_NONE;
    assign fwd_rt_D = reset ? fwd_sel(e_ok_c && A2_D == A3_E, m_ok_c && A2_D == A3_M,
                                      wr_w_c && A2_D == A3_W) : FWD_NONE;
    assign fwd_rs_E = reset ? fwd_sel(1'b0, m_ok_c && A1_E == A3_M,
                                      wr_w_c && A1_E == A3_W) : FWD_NONE;
    assign fwd_rt_E = reset ? fwd_sel(1'b0, m_ok_c && A2_E == A3_M,
                                      wr_w_c && A2_E == A3_W) : FWD_NONE;
    assign fwd_rt_M = reset ? fwd_sel(1'b0, 1'b0, wr_w_c && A2_M == A3_W) : FWD_NONE;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Bench for hazard_md_ctrl: table-level reference model checked every cycle plus directed literal cases.
module tb_hazard_md_ctrl;

`ifdef HAZARD_MD_STALL_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] A1_D, A2_D, A1_E, A2_E, A3_E, A2_M, A3_M, A3_W;
    logic       Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2;
    logic [2:0] res_E, res_M, res_W;
    logic       md_start_E, md_div_E, md_use_D;
    logic       stall, clrE, stall_md, md_busy;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

    hazard_md_ctrl dut (
        .clk(clk), .reset(reset),
        .A1_D(A1_D), .A2_D(A2_D),
        .Tuse_rs0(Tuse_rs0), .Tuse_rs1(Tuse_rs1),
        .Tuse_rt0(Tuse_rt0), .Tuse_rt1(Tuse_rt1), .Tuse_rt2(Tuse_rt2),
        .A1_E(A1_E), .A2_E(A2_E), .A3_E(A3_E), .A2_M(A2_M), .A3_M(A3_M), .A3_W(A3_W),
        .res_E(res_E), .res_M(res_M), .res_W(res_W),
        .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
        .stall(stall), .clrE(clrE), .stall_md(stall_md),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
        .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M), .md_busy(md_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: result-class tables and a "busy until cycle N" view of the md unit.
    function automatic bit is_nw(input logic [2:0] r);
        return !(r >= 3'd1 && r <= 3'd4);
    endfunction

    function automatic int tnew(input int stage, input logic [2:0] r);
        int t_e[5] = '{0, 1, 2, 0, 1};
        if (is_nw(r)) return 0;
        if (stage == 0) return t_e[r];
        if (stage == 1) return (r == 3'd2) ? 1 : 0;
        return 0;
    endfunction

    function automatic bit exp_data_stall();
        int tuse_rs = Tuse_rs0 ? 0 : (Tuse_rs1 ? 1 : -1);
        int tuse_rt = Tuse_rt0 ? 0 : (Tuse_rt1 ? 1 : (Tuse_rt2 ? 2 : -1));
        logic [4:0] a3[2];
        logic [2:0] rs[2];
        a3[0] = A3_E; a3[1] = A3_M;
        rs[0] = res_E; rs[1] = res_M;
        for (int s = 0; s < 2; s++) begin
            if (a3[s] != 5'd0 && !is_nw(rs[s])) begin
                if (tuse_rs >= 0 && A1_D == a3[s] && tnew(s, rs[s]) > tuse_rs) return 1'b1;
                if (tuse_rt >= 0 && A2_D == a3[s] && tnew(s, rs[s]) > tuse_rt) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int exp_fwd(input logic [4:0] a, input int first_stage);
        logic [4:0] a3[3];
        logic [2:0] rs[3];
        a3[0] = A3_E; a3[1] = A3_M; a3[2] = A3_W;
        rs[0] = res_E; rs[1] = res_M; rs[2] = res_W;
        for (int s = first_stage; s < 3; s++)
            if (a3[s] != 5'd0 && !is_nw(rs[s]) && a == a3[s] && tnew(s, rs[s]) == 0)
                return s + 1;
        return 0;
    endfunction

    int cyc      = 0;
    int busy_end = -1;

    always @(posedge clk or negedge reset) begin
        if (!reset) busy_end = -1;
        else begin
            if (MD_EN && !(cyc <= busy_end) && md_start_E)
                busy_end = cyc + (md_div_E ? 10 : 5);
            cyc++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_stall", 32'(stall), 0);
            chk("rst_clrE", 32'(clrE), 0);
            chk("rst_stall_md", 32'(stall_md), 0);
            chk("rst_md_busy", 32'(md_busy), 0);
            chk("rst_fwd_rs_D", 32'(fwd_rs_D), 0);
            chk("rst_fwd_rt_D", 32'(fwd_rt_D), 0);
            chk("rst_fwd_rs_E", 32'(fwd_rs_E), 0);
            chk("rst_fwd_rt_E", 32'(fwd_rt_E), 0);
            chk("rst_fwd_rt_M", 32'(fwd_rt_M), 0);
        end else begin
            bit e_busy, e_smd, e_stall;
            e_busy  = MD_EN && (cyc <= busy_end || md_start_E);
            e_smd   = e_busy && md_use_D;
            e_stall = exp_data_stall() || e_smd;
            chk("m_md_busy", 32'(md_busy), 32'(e_busy));
            chk("m_stall_md", 32'(stall_md), 32'(e_smd));
            chk("m_stall", 32'(stall), 32'(e_stall));
            chk("m_clrE", 32'(clrE), 32'(e_stall));
            chk("m_fwd_rs_D", 32'(fwd_rs_D), exp_fwd(A1_D, 0));
            chk("m_fwd_rt_D", 32'(fwd_rt_D), exp_fwd(A2_D, 0));
            chk("m_fwd_rs_E", 32'(fwd_rs_E), exp_fwd(A1_E, 1));
            chk("m_fwd_rt_E", 32'(fwd_rt_E), exp_fwd(A2_E, 1));
            chk("m_fwd_rt_M", 32'(fwd_rt_M), exp_fwd(A2_M, 2));
        end
    end

    task automatic clr();
        {A1_D, A2_D, A1_E, A2_E, A3_E, A2_M, A3_M, A3_W} = '0;
        {Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2} = '0;
        {res_E, res_M, res_W} = '0;
        {md_start_E, md_div_E, md_use_D} = '0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic md_span(input bit div, input int hold, output int cnt);
        @(posedge clk); #1;
        clr();
        md_use_D = 1'b1; md_div_E = div; md_start_E = 1'b1;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall_md === 1'b1) cnt++;
            @(posedge clk); #1;
            if (i + 1 >= hold) md_start_E = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        clr();
        reset = 1'b0;
        // Inputs that would stall and forward, held under reset.
        A3_E = 5'd8; res_E = 3'd2; A1_D = 5'd8; Tuse_rs0 = 1'b1;
        A3_W = 5'd8; res_W = 3'd1; md_start_E = 1'b1; md_use_D = 1'b1;
        settle();
        chk("reset_stall", 32'(stall), 0);
        chk("reset_md_busy", 32'(md_busy), 0);
        chk("reset_fwd_rs_D", 32'(fwd_rs_D), 0);
        @(posedge clk); #1;
        clr();
        reset = 1'b1;

        clr(); A3_E = 5'd8; res_E = 3'd2; A1_D = 5'd8; Tuse_rs0 = 1'b1; settle();
        chk("lwE_stall", 32'(stall), 1);
        chk("lwE_clrE", 32'(clrE), 1);
        clr(); A3_M = 5'd8; res_M = 3'd2; A1_D = 5'd8; Tuse_rs0 = 1'b1; settle();
        chk("lwM_stall", 32'(stall), 1);
        clr(); A3_W = 5'd8; res_W = 3'd2; A1_D = 5'd8; Tuse_rs0 = 1'b1; settle();
        chk("lwW_stall", 32'(stall), 0);
        chk("lwW_fwd_rs_D", 32'(fwd_rs_D), 3);
        clr(); A3_M = 5'd9; res_M = 3'd1; A2_D = 5'd9; Tuse_rt1 = 1'b1; settle();
        chk("adduM_stall", 32'(stall), 0);
        chk("adduM_fwd_rt_D", 32'(fwd_rt_D), 2);
        clr(); A3_E = 5'd31; res_E = 3'd3; A1_D = 5'd31; Tuse_rs0 = 1'b1; settle();
        chk("jal_stall", 32'(stall), 0);
        chk("jal_fwd_rs_D", 32'(fwd_rs_D), 1);
        clr(); res_E = 3'd1; res_M = 3'd1; res_W = 3'd1; Tuse_rs0 = 1'b1; Tuse_rt0 = 1'b1; settle();
        chk("zero_stall", 32'(stall), 0);
        chk("zero_fwd_all", 32'({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M}), 0);
        clr(); A3_E = 5'd8; res_E = 3'd2; A1_D = 5'd8; A2_D = 5'd8; settle();
        chk("notuse_stall", 32'(stall), 0);
        clr(); A3_E = 5'd8; res_E = 3'd1; A1_D = 5'd8; Tuse_rs1 = 1'b1; settle();
        chk("aluE_rs1_stall", 32'(stall), 0);
        chk("aluE_fwd_rs_D", 32'(fwd_rs_D), 0);
        Tuse_rs0 = 1'b1; settle();
        chk("aluE_rs0_stall", 32'(stall), 1);
        clr(); A3_E = 5'd8; res_E = 3'd2; A2_D = 5'd8; Tuse_rt2 = 1'b1; settle();
        chk("lwE_rt2_stall", 32'(stall), 0);
        Tuse_rt2 = 1'b0; Tuse_rt1 = 1'b1; settle();
        chk("lwE_rt1_stall", 32'(stall), 1);
        clr(); A3_E = 5'd8; res_E = 3'd4; A1_D = 5'd8; Tuse_rs0 = 1'b1; settle();
        chk("mdE_stall", 32'(stall), 1);
        clr(); A3_E = 5'd8; res_E = 3'd5; A1_D = 5'd8; Tuse_rs0 = 1'b1; A3_W = 5'd8; res_W = 3'd1; settle();
        chk("res5_stall", 32'(stall), 0);
        chk("res5_fwd_rs_D", 32'(fwd_rs_D), 3);
        clr(); A3_E = 5'd10; res_E = 3'd3; A3_M = 5'd10; res_M = 3'd1; A1_D = 5'd10; settle();
        chk("prio_fwd_rs_D", 32'(fwd_rs_D), 1);
        clr(); A1_E = 5'd5; A3_E = 5'd5; res_E = 3'd3; A3_M = 5'd5; res_M = 3'd1;
        A2_E = 5'd6; A2_M = 5'd6; A3_W = 5'd6; res_W = 3'd2; settle();
        chk("estage_fwd_rs_E", 32'(fwd_rs_E), 2);
        chk("estage_fwd_rt_E", 32'(fwd_rt_E), 3);
        chk("mstage_fwd_rt_M", 32'(fwd_rt_M), 3);
        clr(); A1_E = 5'd7; A3_M = 5'd7; res_M = 3'd2; settle();
        chk("lwM_fwd_rs_E", 32'(fwd_rs_E), 0);

        md_span(1'b1, 1, cnt);
        chk("div_span", cnt, MD_EN ? 11 : 0);
        md_span(1'b0, 1, cnt);
        chk("mult_span", cnt, MD_EN ? 6 : 0);
        md_span(1'b1, 4, cnt);
        chk("busy_restart_span", cnt, MD_EN ? 11 : 0);

        // Reset pulse in the third BUSY cycle of a div.
        @(posedge clk); #1;
        clr(); md_use_D = 1'b1; md_div_E = 1'b1; md_start_E = 1'b1;
        @(posedge clk); #1; md_start_E = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy3_md_busy", 32'(md_busy), MD_EN ? 1 : 0);
        reset = 1'b0;
        #1;
        chk("rstpulse_md_busy", 32'(md_busy), 0);
        chk("rstpulse_stall", 32'(stall), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        settle();
        chk("post_rst_md_busy", 32'(md_busy), 0);
        chk("post_rst_stall", 32'(stall), 0);
        settle();
        chk("post_rst_md_busy2", 32'(md_busy), 0);

        clr();
        settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_md_ctrl.md
HAZARD_MD_CTRL -- requirements
Module: hazard_md_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-low (reset=0 clears all state immediately).
REQ-003 SHALL have ports A1_D, A2_D, input, 5 each; rs and rt of the D-stage instruction.
REQ-004 SHALL have ports Tuse_rs0, Tuse_rs1, Tuse_rt0, Tuse_rt1, Tuse_rt2, input, 1 each; register needed in D, E or M respectively; all low means not read.
REQ-005 SHALL have ports A1_E, A2_E, A3_E, A2_M, A3_M, A3_W, input, 5 each; pipelined register addresses.
REQ-006 SHALL have ports res_E, res_M, res_W, input, 3 each; result class: 0 NW, 1 ALU, 2 DM, 3 PC, 4 MD; 5-7 treated as NW.
REQ-007 SHALL have ports md_start_E (1, mult/div issued in E this cycle), md_div_E (1, 1=div, 0=mult) and md_use_D (1, D instruction is mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 SHALL have outputs stall (1, freeze PC and D register), clrE (1, bubble E register) and stall_md (1, md-caused portion of stall).
REQ-009 SHALL have outputs fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M, 2 each; 0 no forward, 1 from E (PC+8), 2 from M, 3 from W.
REQ-010 SHALL have output md_busy, 1; mult/div unit occupied.

Function
REQ-011 Tnew in E SHALL be: ALU 1, DM 2, PC 0, MD 1, NW 0; in M: DM 1, all others 0; in W: 0.
REQ-012 Data stall SHALL assert when the D register matches A3_E or A3_M, the address is nonzero, res is not NW, and Tnew exceeds Tuse. Tuse is 0, 1 or 2 for the rs0/rs1 or rt0/rt1/rt2 flag.
REQ-013 A register with no Tuse flag set SHALL never cause a stall.
REQ-014 Forward select SHALL pick the youngest stage (E, then M, then W) with matching nonzero A3, non-NW res and Tnew 0. Otherwise it SHALL be 0.
REQ-015 D-stage selects SHALL use A1_D and A2_D, E-stage selects SHALL use A1_E and A2_E, and fwd_rt_M SHALL use A2_M with W as its only source. Encoding 1 SHALL occur only in D-stage selects.
REQ-016 Mult/div counter SHALL be 4 bits with FSM states IDLE and BUSY.
REQ-017 On md_start_E in IDLE, the FSM SHALL load 5 (mult) or 10 (div) and enter BUSY at the next edge.
REQ-018 In BUSY the counter SHALL decrement once per cycle. At the edge where it reaches 0, the FSM SHALL return to IDLE.
REQ-019 md_busy SHALL equal (state==BUSY) OR md_start_E.
REQ-020 stall_md SHALL equal md_use_D AND md_busy.
REQ-021 md_start_E in BUSY SHALL be ignored; the count is not reloaded.
REQ-022 stall SHALL equal data stall OR stall_md, and clrE SHALL equal stall, both combinational in the same cycle.
REQ-023 Simultaneous data and md stall SHALL yield a single stall with stall_md=1.

Reset
REQ-024 With reset=0, state SHALL be IDLE and counter 0, asynchronously.
REQ-025 With reset=0, stall, clrE, stall_md, md_busy and all fwd selects SHALL be 0.
REQ-026 Reset during BUSY SHALL abort the operation. After release, md_busy SHALL be 0 until the next md_start_E.

Configuration
REQ-027 Macro HAZARD_MD_STALL_EN SHALL compile in the mult/div counter and FSM. When it is defined, REQ-016 to REQ-021 apply.
REQ-028 Without HAZARD_MD_STALL_EN, md_busy and stall_md SHALL be constant 0 and md inputs SHALL be ignored; data stall and forwarding SHALL be unchanged.

Verification
REQ-029 Bench SHALL cover: lw $8 in E (A3_E=8, res_E=2), D beq reads rs=8 with Tuse_rs0 -> stall=1, clrE=1; with the same lw in M -> stall=1; with the lw in W -> stall=0, fwd_rs_D=3.
REQ-030 Bench SHALL cover: addu $9 in M (res_M=1), D reads rt=9 with Tuse_rt1 -> stall=0, fwd_rt_D=2.
REQ-031 Bench SHALL cover: jal in E (A3_E=31, res_E=3), D jr $31 with Tuse_rs0 -> stall=0, fwd_rs_D=1.
REQ-032 Bench SHALL cover: A3_E=0, res_E=1, D reads $0 -> stall=0, all fwd selects 0.
REQ-033 Bench SHALL cover: md_start_E=1 with md_div_E=1, then md_use_D=1 held -> stall_md=1 for 11 cycles (the start cycle plus 10 BUSY), then 0. For mult (md_div_E=0) the span SHALL be 6 cycles.
REQ-034 Bench SHALL cover: reset pulsed low in the 3rd BUSY cycle -> md_busy=0 and stall=0 immediately, state IDLE after release.
